pipeline_ctrl: RTL and testbench

Stall/flush sequencer for the 5-stage pipeline. It drives the write-enable and synchronous-clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write-enable. It resolves load-use hazards, instruction/data memory wait states, taken-branch flushes and HLT draining. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-register enables/clears,
// PC enable, HLT drain sequencing and a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int REG_BITS = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                ex_memrd,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                br_taken,
  input  logic                i_stall,
  input  logic                d_stall,
  input  logic                id_halt,
  output logic                pc_wren,
  output logic                ifid_wren,
  output logic                ifid_clr,
  output logic                idex_wren,
  output logic                idex_clr,
  output logic                exmem_wren,
  output logic                exmem_clr,
  output logic                memwb_wren,
  output logic                memwb_clr,
  output logic                halted,
  output logic [CNT_BITS-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t              state_r;
  logic [1:0]          dcnt_r;
  logic [CNT_BITS-1:0] stall_cnt_r;
  logic                lu_s;
  logic                stall_evt_s;
  logic                pc_wren_s, ifid_wren_s, ifid_clr_s, idex_wren_s, idex_clr_s;
  logic                exmem_wren_s, exmem_clr_s, memwb_wren_s, memwb_clr_s, halted_s;

  // Load-use hazard against the load in EX; register 0 never hazards
  assign lu_s = ex_memrd && (ex_rd != {REG_BITS{1'b0}}) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  // Control decode from state and current-cycle hazard inputs
  always_comb begin
    pc_wren_s    = 1'b1;
    ifid_wren_s  = 1'b1;
    ifid_clr_s   = 1'b0;
    idex_wren_s  = 1'b1;
    idex_clr_s   = 1'b0;
    exmem_wren_s = 1'b1;
    exmem_clr_s  = 1'b0;
    memwb_wren_s = 1'b1;
    memwb_clr_s  = 1'b0;
    halted_s     = 1'b0;
    stall_evt_s  = 1'b0;
    if (!rst) begin
      pc_wren_s    = 1'b0;
      ifid_wren_s  = 1'b0;
      idex_wren_s  = 1'b0;
      exmem_wren_s = 1'b0;
      memwb_wren_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (d_stall) begin
            pc_wren_s    = 1'b0;
            ifid_wren_s  = 1'b0;
            idex_wren_s  = 1'b0;
            exmem_wren_s = 1'b0;
            memwb_clr_s  = 1'b1;
            stall_evt_s  = 1'b1;
          end else if (lu_s) begin
            pc_wren_s   = 1'b0;
            ifid_wren_s = 1'b0;
            idex_clr_s  = 1'b1;
            stall_evt_s = 1'b1;
          end else if (id_halt) begin
            pc_wren_s  = 1'b0;
            ifid_clr_s = 1'b1;
          end else if (br_taken) begin
            ifid_clr_s = 1'b1;
          end else if (i_stall) begin
            pc_wren_s   = 1'b0;
            ifid_clr_s  = 1'b1;
            stall_evt_s = 1'b1;
          end else begin
            stall_evt_s = 1'b0;
          end
        end
        DRAIN: begin
          pc_wren_s  = 1'b0;
          ifid_clr_s = 1'b1;
          if (d_stall) begin
            ifid_wren_s  = 1'b0;
            idex_wren_s  = 1'b0;
            exmem_wren_s = 1'b0;
            memwb_clr_s  = 1'b1;
          end else begin
            ifid_wren_s = 1'b1;
          end
        end
        HALTED: begin
          pc_wren_s    = 1'b0;
          ifid_wren_s  = 1'b0;
          idex_wren_s  = 1'b0;
          exmem_wren_s = 1'b0;
          memwb_wren_s = 1'b0;
          halted_s     = 1'b1;
        end
        default: begin
          pc_wren_s    = 1'b0;
          ifid_wren_s  = 1'b0;
          idex_wren_s  = 1'b0;
          exmem_wren_s = 1'b0;
          memwb_wren_s = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and drain countdown; d_stall freezes the drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= RUN;
      dcnt_r  <= 2'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (!d_stall && !lu_s && id_halt) begin
            state_r <= DRAIN;
            dcnt_r  <= 2'd3;
          end
        end
        DRAIN: begin
          if (!d_stall) begin
            dcnt_r <= dcnt_r - 2'd1;
            if (dcnt_r == 2'd1) begin
              state_r <= HALTED;
            end
          end
        end
        HALTED: begin
          state_r <= HALTED;
        end
        default: begin
          state_r <= RUN;
          dcnt_r  <= 2'd0;
        end
      endcase
    end
  end

  // Saturating count of RUN-state stall cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_BITS{1'b0}};
    end else if (stall_evt_s && (stall_cnt_r != {CNT_BITS{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end
  end

  assign pc_wren    = pc_wren_s;
  assign ifid_wren  = ifid_wren_s;
  assign ifid_clr   = ifid_clr_s;
  assign idex_wren  = idex_wren_s;
  assign idex_clr   = idex_clr_s;
  assign exmem_wren = exmem_wren_s;
  assign exmem_clr  = exmem_clr_s;
  assign memwb_wren = memwb_wren_s;
  assign memwb_clr  = memwb_clr_s;
  assign halted     = halted_s;
  assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (CNT_BITS = 4 build): directed hazard,
// halt, reset and saturation sequences followed by randomized cycles.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_rs, id_rt, ex_rd;
  logic id_uses_rs, id_uses_rt, ex_memrd, br_taken, i_stall, d_stall, id_halt;
  logic pc_wren, ifid_wren, ifid_clr, idex_wren, idex_clr;
  logic exmem_wren, exmem_clr, memwb_wren, memwb_clr, halted;
  logic [3:0] stall_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REG_BITS(4), .CNT_BITS(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_memrd(ex_memrd),
    .ex_rd(ex_rd), .br_taken(br_taken), .i_stall(i_stall), .d_stall(d_stall),
    .id_halt(id_halt), .pc_wren(pc_wren), .ifid_wren(ifid_wren),
    .ifid_clr(ifid_clr), .idex_wren(idex_wren), .idex_clr(idex_clr),
    .exmem_wren(exmem_wren), .exmem_clr(exmem_clr), .memwb_wren(memwb_wren),
    .memwb_clr(memwb_clr), .halted(halted), .stall_cnt(stall_cnt)
  );

  // Expected vector order: pc_w, ifid_w, ifid_c, idex_w, idex_c, exmem_w, exmem_c, memwb_w, memwb_c, halted
  localparam logic [9:0] V_DEFAULT = 10'b1101010100;
  localparam logic [9:0] V_DSTALL  = 10'b0000000110;
  localparam logic [9:0] V_LU      = 10'b0001110100;
  localparam logic [9:0] V_SQUASH  = 10'b0111010100;
  localparam logic [9:0] V_BRANCH  = 10'b1111010100;
  localparam logic [9:0] V_DRN_DS  = 10'b0010000110;
  localparam logic [9:0] V_HALTED  = 10'b0000000001;
  localparam logic [9:0] V_RESET   = 10'b0000000000;

  typedef struct {
    logic [9:0] ctrl;
    logic [3:0] cnt;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: halt flag, remaining drain cycles, stall count
  bit m_halted = 1'b0;
  int m_drain  = 0;
  int m_cnt    = 0;

  task automatic cyc(input bit r, input bit mr, input int rd, input int rs, input int rt,
                     input bit urs, input bit urt, input bit br, input bit is,
                     input bit ds, input bit hl, input string tag);
    logic [9:0] e;
    int c;
    bit hz;
    bit stall;
    hz = mr && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
    stall = 1'b0;
    c = m_cnt;
    if (!r) begin
      e = V_RESET;
      m_halted = 1'b0;
      m_drain = 0;
      m_cnt = 0;
      c = 0;
    end else if (m_halted) begin
      e = V_HALTED;
    end else if (m_drain > 0) begin
      e = ds ? V_DRN_DS : V_SQUASH;
      if (!ds) begin
        m_drain = m_drain - 1;
        if (m_drain == 0) m_halted = 1'b1;
      end
    end else begin
      if (ds)      begin e = V_DSTALL; stall = 1'b1; end
      else if (hz) begin e = V_LU;     stall = 1'b1; end
      else if (hl) begin e = V_SQUASH; m_drain = 3;  end
      else if (br) begin e = V_BRANCH; end
      else if (is) begin e = V_SQUASH; stall = 1'b1; end
      else         begin e = V_DEFAULT; end
      if (stall) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
    end
    rst = r; ex_memrd = mr; ex_rd = rd[3:0]; id_rs = rs[3:0]; id_rt = rt[3:0];
    id_uses_rs = urs; id_uses_rt = urt; br_taken = br; i_stall = is;
    d_stall = ds; id_halt = hl;
    q.push_back('{e, c[3:0], tag});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle
  initial begin
    exp_t x;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        act = {pc_wren, ifid_wren, ifid_clr, idex_wren, idex_clr,
               exmem_wren, exmem_clr, memwb_wren, memwb_clr, halted};
        n_tests++;
        if (act !== x.ctrl) begin
          n_fail++;
          $display("FAIL %s ctrl: got %b expected %b", x.tag, act, x.ctrl);
        end
        n_tests++;
        if (stall_cnt !== x.cnt) begin
          n_fail++;
          $display("FAIL %s stall_cnt: got %0d expected %0d", x.tag, stall_cnt, x.cnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; ex_memrd = 1'b0; ex_rd = 4'd0; id_rs = 4'd0; id_rt = 4'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; br_taken = 1'b0; i_stall = 1'b0;
    d_stall = 1'b0; id_halt = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    cyc(0, 1, 3, 3, 0, 1, 0, 1, 1, 1, 1, "reset_busy");
    idle(1, "default");
    cyc(1, 1, 3, 3, 0, 1, 0, 0, 0, 0, 0, "load_use");
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, "load_use_r0");
    cyc(1, 1, 5, 0, 5, 0, 1, 0, 0, 0, 0, "load_use_rt");
    cyc(1, 1, 5, 0, 5, 0, 0, 0, 0, 0, 0, "rt_unused");
    for (int i = 0; i < 3; i++) cyc(1, 1, 3, 3, 0, 1, 0, 1, 0, 1, 0, "dstall_prio");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, "br_over_istall");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "istall");
    idle(2, "pre_halt");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, "halt");
    idle(1, "drain1");
    cyc(1, 1, 3, 3, 0, 1, 0, 1, 1, 1, 1, "drain_dstall");
    idle(2, "drain_tail");
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 3, 3, 3, 1, 1, 1, 1, $urandom_range(0, 1), 1, "halted_hold");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_from_halt");
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "cnt_to_5");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "halt2");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "drain_dstall2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "reset_mid_drain");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "reset_hold");
    idle(1, "after_release");
    for (int i = 0; i < 18; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "saturate");
    idle(1, "saturated");
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 39) != 0, $urandom_range(0, 1), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 24) == 0, "random");
    repeat (2) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: got %0d entries left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
